// File: rtl/note_scheduler.sv
// Timed note sequencer/arbiter feeding the audio block: SFX beats BGM, rests are inserted between notes.
// Optional feature macro: SFX_PREEMPT_EN (an SFX request may cut short a BGM note in HOLD).
module note_scheduler #(
    parameter int TICK_DIV = 1_000_000,
    parameter int DUR_W    = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             bgm_valid,
    input  logic [3:0]       bgm_note,
    input  logic [DUR_W-1:0] bgm_dur,
    output logic             bgm_ready,
    input  logic             sfx_valid,
    input  logic [3:0]       sfx_note,
    input  logic [DUR_W-1:0] sfx_dur,
    output logic             sfx_ready,
    output logic [3:0]       note,
    output logic             note_en,
    output logic             busy,
    output logic             src
);

    typedef enum logic [1:0] {IDLE, LOAD, FIRE, HOLD} state_t;

    localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    state_t             state_q, state_d;
    logic [3:0]         note_q, note_d;
    logic               src_q, src_d;
    logic               note_en_q, note_en_d;
    logic               silent_q, silent_d;
    logic [DUR_W-1:0]   dcnt_q, dcnt_d;
    logic [PW-1:0]      pre_q, pre_d;

    // A zero-length request still sounds for one full tick.
    function automatic logic [DUR_W-1:0] dur_ticks(input logic [DUR_W-1:0] d);
        return (d == '0) ? DUR_W'(1) : d;
    endfunction

    always_comb begin
        state_d   = state_q;
        note_d    = note_q;
        src_d     = src_q;
        note_en_d = 1'b0;
        silent_d  = silent_q;
        dcnt_d    = dcnt_q;
        pre_d     = pre_q;
        bgm_ready = 1'b0;
        sfx_ready = 1'b0;

        case (state_q)
            IDLE: begin
                if (sfx_valid) begin
                    sfx_ready = 1'b1;
                    note_d    = sfx_note;
                    src_d     = 1'b1;
                    dcnt_d    = dur_ticks(sfx_dur);
                    silent_d  = 1'b0;
                    state_d   = LOAD;
                end else begin
                    bgm_ready = 1'b1;
                    if (bgm_valid) begin
                        note_d   = bgm_note;
                        src_d    = 1'b0;
                        dcnt_d   = dur_ticks(bgm_dur);
                        silent_d = 1'b0;
                        state_d  = LOAD;
                    end else if (!silent_q) begin
                        // Gap in the stream: play one rest so the previous note stops.
                        note_d   = 4'h0;
                        silent_d = 1'b1;
                        state_d  = LOAD;
                    end
                end
            end
            LOAD: begin
                note_en_d = 1'b1;
                state_d   = FIRE;
            end
            FIRE: begin
                pre_d   = '0;
                state_d = silent_q ? IDLE : HOLD;
            end
            HOLD: begin
                if (pre_q == PRE_LAST) begin
                    pre_d  = '0;
                    dcnt_d = dcnt_q - DUR_W'(1);
                    if (dcnt_q == DUR_W'(1)) begin
                        state_d = IDLE;
                    end
                end else begin
                    pre_d = pre_q + PW'(1);
                end
`ifdef SFX_PREEMPT_EN
                if (!src_q) begin
                    sfx_ready = sfx_valid;
                    if (sfx_valid) begin
                        note_d   = sfx_note;
                        src_d    = 1'b1;
                        dcnt_d   = dur_ticks(sfx_dur);
                        silent_d = 1'b0;
                        state_d  = LOAD;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        if (!rstn) begin
            bgm_ready = 1'b0;
            sfx_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            note_q    <= 4'h0;
            src_q     <= 1'b0;
            note_en_q <= 1'b0;
            silent_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            note_q    <= note_d;
            src_q     <= src_d;
            note_en_q <= note_en_d;
            silent_q  <= silent_d;
        end
    end

    always_ff @(posedge clk) begin
        dcnt_q <= dcnt_d;
        pre_q  <= pre_d;
    end

    assign note    = note_q;
    assign note_en = note_en_q;
    assign src     = src_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler (TICK_DIV=4): cycle table plus priority, zero-duration, preemption and reset sequences.
module tb_note_scheduler;

    logic       clk;
    logic       rstn;
    logic       bgm_valid, sfx_valid;
    logic [3:0] bgm_note, sfx_note;
    logic [7:0] bgm_dur, sfx_dur;
    logic       bgm_ready, sfx_ready;
    logic [3:0] note;
    logic       note_en, busy, src;

    int total = 0;
    int bad   = 0;

    note_scheduler #(.TICK_DIV(4), .DUR_W(8)) dut (
        .clk(clk), .rstn(rstn),
        .bgm_valid(bgm_valid), .bgm_note(bgm_note), .bgm_dur(bgm_dur), .bgm_ready(bgm_ready),
        .sfx_valid(sfx_valid), .sfx_note(sfx_note), .sfx_dur(sfx_dur), .sfx_ready(sfx_ready),
        .note(note), .note_en(note_en), .busy(busy), .src(src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rstn;
        logic       bv;
        logic [3:0] bn;
        logic [7:0] bd;
        logic       sv;
        logic [3:0] note;
        logic       en;
        logic       busy;
        logic       src;
        logic       br;
        logic       sr;
    } vec_t;

    vec_t vq[$];

    task automatic add(input int rep, input logic r, input logic bv, input logic [3:0] bn,
                       input logic [7:0] bd, input logic sv, input logic [3:0] n, input logic en,
                       input logic bz, input logic s, input logic br, input logic sr);
        vec_t v;
        v.rstn = r; v.bv = bv; v.bn = bn; v.bd = bd; v.sv = sv;
        v.note = n; v.en = en; v.busy = bz; v.src = s; v.br = br; v.sr = sr;
        for (int k = 0; k < rep; k++) vq.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h want=%0h", nm, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        rstn = 1'b0; bgm_valid = 1'b0; sfx_valid = 1'b0;
        bgm_note = 4'h0; bgm_dur = 8'd0; sfx_note = 4'h0; sfx_dur = 8'd0;

        // Reset with both valids high, then one BGM note 5 for 3 ticks followed by the rest.
        add(3,  1'b0, 1'b1, 4'h5, 8'd3, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1,  1'b1, 1'b0, 4'h0, 8'd0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1,  1'b1, 1'b1, 4'h5, 8'd3, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1,  1'b1, 1'b0, 4'h0, 8'd0, 1'b0, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1,  1'b1, 1'b0, 4'h0, 8'd0, 1'b0, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        add(12, 1'b1, 1'b0, 4'h0, 8'd0, 1'b0, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1,  1'b1, 1'b0, 4'h0, 8'd0, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1,  1'b1, 1'b0, 4'h0, 8'd0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1,  1'b1, 1'b0, 4'h0, 8'd0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        add(3,  1'b1, 1'b0, 4'h0, 8'd0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < vq.size(); i++) begin
            tick();
            rstn = vq[i].rstn; bgm_valid = vq[i].bv; bgm_note = vq[i].bn; bgm_dur = vq[i].bd;
            sfx_valid = vq[i].sv; sfx_note = 4'hF; sfx_dur = 8'd1;
            #1;
            chk("vec.note", i, 32'(note), 32'(vq[i].note));
            chk("vec.note_en", i, 32'(note_en), 32'(vq[i].en));
            chk("vec.busy", i, 32'(busy), 32'(vq[i].busy));
            chk("vec.src", i, 32'(src), 32'(vq[i].src));
            chk("vec.bgm_ready", i, 32'(bgm_ready), 32'(vq[i].br));
            chk("vec.sfx_ready", i, 32'(sfx_ready), 32'(vq[i].sr));
        end

        // Priority: SFX 9/1 beats BGM 1/2; BGM follows directly after the SFX hold.
        tick();
        bgm_valid = 1'b1; bgm_note = 4'h1; bgm_dur = 8'd2;
        sfx_valid = 1'b1; sfx_note = 4'h9; sfx_dur = 8'd1;
        #1;
        chk("prio.sfx_ready", 0, 32'(sfx_ready), 32'd1);
        chk("prio.bgm_ready", 0, 32'(bgm_ready), 32'd0);
        tick(); sfx_valid = 1'b0; #1;
        chk("prio.note", 1, 32'(note), 32'h9);
        chk("prio.src", 1, 32'(src), 32'd1);
        tick(); #1;
        chk("prio.note_en", 2, 32'(note_en), 32'd1);
        for (int k = 3; k <= 6; k++) begin
            tick(); #1;
            chk("prio.hold_en", k, 32'(note_en), 32'd0);
            chk("prio.hold_bgm_ready", k, 32'(bgm_ready), 32'd0);
        end
        tick(); #1;
        chk("prio.idle_busy", 7, 32'(busy), 32'd0);
        chk("prio.idle_bgm_ready", 7, 32'(bgm_ready), 32'd1);
        chk("prio.no_rest_note", 7, 32'(note), 32'h9);
        tick(); bgm_valid = 1'b0; #1;
        chk("prio.bgm_note", 8, 32'(note), 32'h1);
        chk("prio.bgm_src", 8, 32'(src), 32'd0);
        repeat (20) tick();

        // Zero duration holds for exactly one tick (4 cycles).
        tick(); bgm_valid = 1'b1; bgm_note = 4'h3; bgm_dur = 8'd0; #1;
        chk("zero.bgm_ready", 0, 32'(bgm_ready), 32'd1);
        tick(); bgm_valid = 1'b0;
        repeat (4) tick();
        tick(); #1;
        chk("zero.busy_last_hold", 6, 32'(busy), 32'd1);
        tick(); #1;
        chk("zero.busy_idle", 7, 32'(busy), 32'd0);
        repeat (6) tick();

        // SFX arrives during a 10-tick BGM hold.
        tick(); bgm_valid = 1'b1; bgm_note = 4'h2; bgm_dur = 8'd10; #1;
        chk("pre.bgm_ready", 0, 32'(bgm_ready), 32'd1);
        tick(); bgm_valid = 1'b0;
        repeat (6) tick();
        tick(); sfx_valid = 1'b1; sfx_note = 4'hA; sfx_dur = 8'd1; #1;
`ifdef SFX_PREEMPT_EN
        chk("pre.sfx_ready", 8, 32'(sfx_ready), 32'd1);
        tick(); sfx_valid = 1'b0; #1;
        chk("pre.note", 9, 32'(note), 32'hA);
        chk("pre.src", 9, 32'(src), 32'd1);
        tick(); #1;
        chk("pre.note_en", 10, 32'(note_en), 32'd1);
`else
        chk("pre.sfx_ready", 8, 32'(sfx_ready), 32'd0);
        for (int k = 9; k <= 42; k++) begin
            tick(); #1;
            chk("pre.wait_sfx_ready", k, 32'(sfx_ready), 32'd0);
            chk("pre.wait_note", k, 32'(note), 32'h2);
        end
        tick(); #1;
        chk("pre.idle_busy", 43, 32'(busy), 32'd0);
        chk("pre.idle_sfx_ready", 43, 32'(sfx_ready), 32'd1);
        tick(); sfx_valid = 1'b0; #1;
        chk("pre.note", 44, 32'(note), 32'hA);
        chk("pre.src", 44, 32'(src), 32'd1);
        tick(); #1;
        chk("pre.note_en", 45, 32'(note_en), 32'd1);
`endif
        repeat (14) tick();

        // Reset pulse during HOLD returns silently to IDLE.
        tick(); bgm_valid = 1'b1; bgm_note = 4'h7; bgm_dur = 8'd5; #1;
        chk("rst.bgm_ready", 0, 32'(bgm_ready), 32'd1);
        tick(); bgm_valid = 1'b0;
        repeat (4) tick();
        tick(); rstn = 1'b0; #1;
        chk("rst.busy_before", 6, 32'(busy), 32'd1);
        chk("rst.note_before", 6, 32'(note), 32'h7);
        tick(); rstn = 1'b1; #1;
        chk("rst.note", 7, 32'(note), 32'h0);
        chk("rst.busy", 7, 32'(busy), 32'd0);
        chk("rst.src", 7, 32'(src), 32'd0);
        pulses = 0;
        repeat (20) begin
            tick(); #1;
            if (note_en) pulses++;
        end
        chk("rst.no_pulse", 0, 32'(pulses), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
